// File: rtl/nibble_acc_pkg.sv
// Shared widths, FSM state encoding and sizing helper for the nibble accumulator.
// Imported by the interface and the accumulator top.
package nibble_acc_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [0:0] {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int smp_cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/nibble_accumulator_if.sv
// Sample input and group-result output of the nibble accumulator.
// master drives samples and result acceptance; slave is the accumulator.
interface nibble_accumulator_if
    import nibble_acc_pkg::*;
#(
    parameter int CNT_W = 3
);
    logic                in_valid;
    logic                in_ready;
    logic [NIBBLE_W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [NIBBLE_W-1:0] out_sum;
    logic                out_ovf;
    logic [CNT_W-1:0]    out_ovf_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_ovf_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_ovf_cnt
    );
endinterface

// File: rtl/top_adder.sv
// 4-bit ripple-carry adder; Overflow is the carry out of the top bit.
// Latency: combinational. Backpressure: none.
// Feeds the accumulator its next running sum.
module top_adder (
    input  logic [3:0] InA,
    input  logic [3:0] InB,
    output logic [3:0] OutSum,
    output logic       Overflow
);
    logic carry;

    always_comb begin
        OutSum = '0;
        carry  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            OutSum[i] = InA[i] ^ InB[i] ^ carry;
            carry     = (InA[i] & InB[i]) | (carry & (InA[i] ^ InB[i]));
        end
        Overflow = carry;
    end
endmodule

// File: rtl/nibble_accumulator.sv
// Accumulates NUM_SAMPLES nibbles through top_adder and reports sum plus overflow stats.
// Latency: result valid the cycle after the last sample is accepted.
// Backpressure: result held while out_ready is low; no input accepted until it is taken.
module nibble_accumulator
    import nibble_acc_pkg::*;
#(
    parameter int NUM_SAMPLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    nibble_accumulator_if.slave  bus
);
    localparam int                 SMP_W    = smp_cnt_width(NUM_SAMPLES);
    localparam logic [SMP_W-1:0]   LAST_SMP = SMP_W'(NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

    state_e              state_q,   state_d;
    logic [NIBBLE_W-1:0] acc_q,     acc_d;
    logic [SMP_W-1:0]    smp_cnt_q, smp_cnt_d;
    logic                ovf_q,     ovf_d;
    logic [CNT_W-1:0]    ovf_cnt_q, ovf_cnt_d;

    logic [NIBBLE_W-1:0] add_sum;
    logic                add_ovf;

    top_adder u_adder (
        .InA      (acc_q),
        .InB      (bus.in_data),
        .OutSum   (add_sum),
        .Overflow (add_ovf)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        smp_cnt_d = smp_cnt_q;
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;

        // clr wins over both handshakes and drops any pending result.
        if (clr) begin
            state_d   = S_ACC;
            acc_d     = '0;
            smp_cnt_d = '0;
            ovf_d     = 1'b0;
            ovf_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_ACC: begin
                    if (bus.in_valid) begin
                        acc_d = add_sum;
                        if (add_ovf) begin
                            ovf_d = 1'b1;
                            if (ovf_cnt_q != CNT_MAX) begin
                                ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
                            end
                        end
                        if (smp_cnt_q == LAST_SMP) begin
                            smp_cnt_d = '0;
                            state_d   = S_OUT;
                        end else begin
                            smp_cnt_d = smp_cnt_q + SMP_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        state_d   = S_ACC;
                        acc_d     = '0;
                        ovf_d     = 1'b0;
                        ovf_cnt_d = '0;
                    end
                end
                default: state_d = S_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_ACC;
            acc_q     <= '0;
            smp_cnt_q <= '0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            smp_cnt_q <= smp_cnt_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign bus.in_ready    = (state_q == S_ACC);
    assign bus.out_valid   = (state_q == S_OUT);
    assign bus.out_sum     = acc_q;
    assign bus.out_ovf     = ovf_q;
    assign bus.out_ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_nibble_accumulator.sv
// Scoreboard bench: two accumulators (CNT_W=3 and CNT_W=1) share one stimulus stream;
// a negedge monitor predicts transfers and checks results against a group-sum model.
module tb_nibble_accumulator;
    import nibble_acc_pkg::*;

    localparam int NS = 4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       clr       = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] in_data   = 4'd0;

    int checks   = 0;
    int failures = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        int sum;
        int ovf;
        int cnt_a;
        int cnt_b;
    } exp_t;

    exp_t exp_q[$];
    int   grp[$];
    bit   m_out = 1'b0;

    nibble_accumulator_if #(.CNT_W(3)) if_a ();
    nibble_accumulator_if #(.CNT_W(1)) if_b ();

    assign if_a.in_valid  = in_valid;
    assign if_a.in_data   = in_data;
    assign if_a.out_ready = out_ready;
    assign if_b.in_valid  = in_valid;
    assign if_b.in_data   = in_data;
    assign if_b.out_ready = out_ready;

    nibble_accumulator #(.NUM_SAMPLES(NS), .CNT_W(3)) dut_a (
        .clk (clk), .rst_n (rst_n), .clr (clr), .bus (if_a.slave)
    );
    nibble_accumulator #(.NUM_SAMPLES(NS), .CNT_W(1)) dut_b (
        .clk (clk), .rst_n (rst_n), .clr (clr), .bus (if_b.slave)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Group result from plain arithmetic: every time the running total reaches 16 is an overflow.
    function automatic exp_t model(input int s[$]);
        exp_t e;
        int   r;
        int   n;
        r = 0;
        n = 0;
        foreach (s[i]) begin
            if (r + s[i] >= 16) n++;
            r = (r + s[i]) % 16;
        end
        e.sum   = r;
        e.ovf   = (n > 0) ? 1 : 0;
        e.cnt_a = (n > 7) ? 7 : n;
        e.cnt_b = (n > 1) ? 1 : n;
        return e;
    endfunction

    // Monitor: compare visible outputs, then predict what the coming edge transfers.
    always @(negedge clk) begin
        if (!rst_n) begin
            grp.delete();
            exp_q.delete();
            m_out = 1'b0;
        end else begin
            chk("in_ready_a", int'(if_a.in_ready), int'(!m_out));
            chk("out_valid_a", int'(if_a.out_valid), int'(m_out));
            chk("out_valid_b", int'(if_b.out_valid), int'(m_out));
            if (if_a.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("sb_sum_a", int'(if_a.out_sum), exp_q[0].sum);
                    chk("sb_ovf_a", int'(if_a.out_ovf), exp_q[0].ovf);
                    chk("sb_cnt_a", int'(if_a.out_ovf_cnt), exp_q[0].cnt_a);
                    chk("sb_sum_b", int'(if_b.out_sum), exp_q[0].sum);
                    chk("sb_cnt_b", int'(if_b.out_ovf_cnt), exp_q[0].cnt_b);
                end
            end
            if (clr) begin
                grp.delete();
                if (m_out && exp_q.size() > 0) void'(exp_q.pop_front());
                m_out = 1'b0;
            end else if (!m_out && in_valid) begin
                grp.push_back(int'(in_data));
                if (grp.size() == NS) begin
                    exp_q.push_back(model(grp));
                    grp.delete();
                    m_out = 1'b1;
                end
            end else if (m_out && out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_out = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'(d);
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = if_a.in_ready;
            tick();
        end
        in_valid = 1'b0;
        chk("send_accepted", int'(ok), 1);
    endtask

    task automatic send4(input int a, input int b, input int c, input int d);
        send(a); send(b); send(c); send(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_out_valid", int'(if_a.out_valid), 0);
        chk("rst_out_sum", int'(if_a.out_sum), 0);
        chk("rst_out_ovf", int'(if_a.out_ovf), 0);
        chk("rst_out_ovf_cnt", int'(if_a.out_ovf_cnt), 0);
        chk("rst_in_ready", int'(if_a.in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic group
        send4(1, 2, 3, 4);
        chk("t1_valid", int'(if_a.out_valid), 1);
        chk("t1_sum", int'(if_a.out_sum), 10);
        chk("t1_ovf", int'(if_a.out_ovf), 0);
        chk("t1_cnt", int'(if_a.out_ovf_cnt), 0);
        chk("t1_in_ready", int'(if_a.in_ready), 0);
        tick();

        // Overflow
        send4(9, 9, 9, 9);
        chk("t2_sum", int'(if_a.out_sum), 4);
        chk("t2_ovf", int'(if_a.out_ovf), 1);
        chk("t2_cnt", int'(if_a.out_ovf_cnt), 2);
        tick();

        // Backpressure with a pending sample that must not be absorbed
        out_ready = 1'b0;
        send4(1, 2, 3, 4);
        in_valid = 1'b1;
        in_data  = 4'd7;
        repeat (5) begin
            tick();
            chk("t3_hold_sum", int'(if_a.out_sum), 10);
            chk("t3_hold_in_ready", int'(if_a.in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t3_release_valid", int'(if_a.out_valid), 0);
        chk("t3_release_in_ready", int'(if_a.in_ready), 1);
        chk("t3_release_acc", int'(if_a.out_sum), 0);
        send4(2, 2, 2, 2);
        chk("t3_next_sum", int'(if_a.out_sum), 8);
        tick();

        // Clear mid-group, then clear while a result is pending
        send(5); send(6);
        clr = 1'b1; tick(); clr = 1'b0;
        send4(1, 1, 1, 1);
        chk("t4_sum", int'(if_a.out_sum), 4);
        chk("t4_ovf", int'(if_a.out_ovf), 0);
        tick();
        out_ready = 1'b0;
        send4(3, 3, 3, 3);
        tick();
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t4_clr_out_valid", int'(if_a.out_valid), 0);
        chk("t4_clr_in_ready", int'(if_a.in_ready), 1);
        out_ready = 1'b1;

        // Asynchronous reset while an overflowed result is held
        out_ready = 1'b0;
        send4(9, 9, 9, 9);
        chk("t5_pre_ovf", int'(if_a.out_ovf), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", int'(if_a.out_valid), 0);
        chk("t5_async_ovf", int'(if_a.out_ovf), 0);
        chk("t5_async_cnt", int'(if_a.out_ovf_cnt), 0);
        chk("t5_async_cnt_b", int'(if_b.out_ovf_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send4(1, 2, 3, 4);
        chk("t5_after_sum", int'(if_a.out_sum), 10);
        tick();

        // Gapped input and counter saturation on the narrow instance
        send(1); send(2); idle(2); send(3); idle(3); send(4);
        chk("t6_gap_sum", int'(if_a.out_sum), 10);
        tick();
        send4(15, 15, 15, 15);
        chk("t6_sat_sum_b", int'(if_b.out_sum), 12);
        chk("t6_sat_cnt_b", int'(if_b.out_ovf_cnt), 1);
        chk("t6_cnt_a", int'(if_a.out_ovf_cnt), 3);
        tick();

        // Random groups with random backpressure, gaps and occasional clears
        rand_rdy = 1'b1;
        repeat (25) begin
            repeat (NS) begin
                send(int'($urandom_range(0, 15)));
                idle(int'($urandom_range(0, 2)));
            end
            if ($urandom_range(0, 9) == 0) begin
                clr = 1'b1; tick(); clr = 1'b0;
            end
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        idle(3);
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_accumulator.md
Name: nibble_accumulator

Overview:
Sequential front end for the 4-bit ripple adder (top_adder). It accepts a stream of 4-bit samples over a valid/ready handshake and feeds each one to the adder together with the running accumulator. It captures the adder's sum and overflow, and after NUM_SAMPLES accepted samples presents the group result on a valid/ready output port. It supplies the adder's operands and consumes everything the adder produces.

Parameters:
NUM_SAMPLES, 4, samples accumulated per output result; legal range 1..15.
CNT_W, 3, width of the overflow-event counter; the counter saturates at 2^CNT_W-1.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
clr  in  1  synchronous clear of the group in progress; highest synchronous priority.
in_valid  in  1  in_data is valid.
in_ready  out  1  block can accept a sample; high in S_ACC only.
in_data  in  4  sample to accumulate.
out_valid  out  1  group result is valid.
out_ready  in  1  consumer accepts the result.
out_sum  out  4  accumulated sum, modulo 16.
out_ovf  out  1  sticky flag: at least one adder overflow occurred in this group.
out_ovf_cnt  out  CNT_W  number of adder overflows in this group, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Internal state: state=S_ACC, acc=0, smp_cnt=0.
  - Outputs: out_valid=0, out_sum=0, out_ovf=0, out_ovf_cnt=0.
  - in_ready=1, because it is decoded from state. No transfer is recorded while reset is asserted.
- Adder connection:
  - InA=acc, InB=in_data.
  - Adder outputs are combinational, so the sum and overflow are used in the same cycle as the accept.
- S_ACC:
  - in_ready=1, out_valid=0.
  - Accept means in_valid and in_ready at a rising edge. On accept:
    - acc <= OutSum (wraps modulo 16).
    - If the adder overflow output is 1: out_ovf <= 1 and out_ovf_cnt increments, saturating at 2^CNT_W-1.
    - smp_cnt increments.
  - When an accept happens with smp_cnt==NUM_SAMPLES-1: next state is S_OUT, out_valid <= 1, smp_cnt <= 0.
  - Cycles with in_valid low change nothing.
- S_OUT:
  - in_ready=0, out_valid=1.
  - out_sum, out_ovf and out_ovf_cnt stay stable while out_ready is low, for any duration.
  - When out_ready is high at an edge: acc, out_ovf and out_ovf_cnt <= 0, out_valid <= 0, next state is S_ACC.
  - No sample is accepted in the handoff cycle. This gives a mandatory one-cycle bubble between groups.
- Result latency: out_valid rises on the edge that accepts the last sample of the group, so it is visible in the following cycle.
- out_sum equals acc at all times. It is meaningful only while out_valid=1.
- clr:
  - When high at an edge, the block returns to the S_ACC reset values from any state. This overrides any accept or output handshake in the same cycle.
  - If the block is in S_OUT, out_valid drops and the result is discarded.
- NUM_SAMPLES=1: every accepted sample produces a result, out_sum=in_data, overflow is always 0.
- Throughput: one sample per cycle inside a group; NUM_SAMPLES+1 cycles minimum per group.

Decomposition:
- Package nibble_acc_pkg holds:
  - NIBBLE_W=4.
  - The state enum {S_ACC, S_OUT}, 1 bit.
  - A function giving the smp_cnt width from NUM_SAMPLES.
- Sub-module: instantiate the existing top_adder once for the addition. No other sub-modules.
- The FSM, counters and registers live in nibble_accumulator.

Test Plan:
1. Basic group: reset, out_ready=1, send 1,2,3,4 back-to-back.
   -> out_valid=1 the cycle after the 4th accept; out_sum=0xA, out_ovf=0, out_ovf_cnt=0; in_ready=0 for that cycle.
2. Overflow: send 9,9,9,9.
   -> running acc is 9, 2 (overflow), 11, 4 (overflow); out_sum=0x4, out_ovf=1, out_ovf_cnt=2.
3. Backpressure: complete the group from test 1 with out_ready=0 for 5 cycles while in_valid=1 with data 7.
   -> outputs held at 0xA, in_ready=0, data 7 not accumulated.
   -> Raise out_ready: the next cycle shows out_valid=0, in_ready=1, and the next group starts from acc=0.
4. Clear mid-group: accept 5,6, then pulse clr; send 1,1,1,1.
   -> out_sum=0x4, out_ovf=0.
   -> Repeat with clr asserted while in S_OUT: out_valid drops the next cycle and the result is lost.
5. Async reset: drive rst_n low mid-cycle during S_OUT with out_ovf=1.
   -> out_valid, out_ovf and out_ovf_cnt go to 0 immediately, without waiting for a clock edge.
   -> After release, group 1,2,3,4 gives 0xA.
6. Gapped input: send 1,2,3,4 with in_valid low for 0, 2 and 3 idle cycles between samples.
   -> Same result as test 1; out_valid only after the 4th accept.
   -> With CNT_W=1 and input 15,15,15,15: out_ovf_cnt saturates at 1, out_sum=0xC.
